// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory, redirect and decode handshake bundle for
// the fetch stage. The pc_misaligned signal exists only when
// FETCH_ALIGN_CHECK_EN is defined.
`timescale 1ns/1ps

interface fetch_queue_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  // fetch stage side
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output pc_misaligned,
`endif
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  // memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
`ifdef FETCH_ALIGN_CHECK_EN
    input  pc_misaligned,
`endif
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC register, single-outstanding fetch to a one-cycle
// synchronous instruction memory, and a DEPTH-entry queue feeding decode.
// A redirect flushes the queue and the in-flight fetch and reloads the PC.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target raises a
// sticky pc_misaligned halt instead of being silently aligned.
`timescale 1ns/1ps

module fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_queue_if.master fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0] r_pc;
  logic        r_rsp_pending;
  logic [63:0] r_rsp_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0] r_q_inst [DEPTH];
  logic [63:0] r_q_pc   [DEPTH];

  logic        w_redirect;
  logic        w_halt;
  logic [CW:0] w_occupancy;
  logic        w_space;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_valid;
  logic [63:0] w_load_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_halt;
  assign w_halt    = r_halt;
  assign w_load_pc = fq.redirect_pc;
`else
  assign w_halt    = 1'b0;
  // low two bits of the target are dropped so the PC stays word aligned
  assign w_load_pc = fq.redirect_pc & ~64'h3;
`endif

  assign w_redirect  = fq.redirect_valid;
  // queued entries plus the fetch in flight must leave room for one more
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_rsp_pending};
  assign w_space     = w_occupancy < (CW+1)'(DEPTH);
  // rst_n gate keeps the request low while reset is held
  assign w_issue     = rst_n && w_space && !w_redirect && !w_halt;
  assign w_push      = r_rsp_pending && !w_redirect;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && fq.inst_ready && !w_redirect;

  assign fq.imem_req   = w_issue;
  assign fq.imem_addr  = r_pc;
  assign fq.inst_valid = w_valid;
  // head is masked when empty so stale storage never shows on the outputs
  assign fq.inst       = w_valid ? r_q_inst[r_rd_ptr] : 32'h0;
  assign fq.inst_pc    = w_valid ? r_q_pc[r_rd_ptr]   : 64'h0;

  // PC, in-flight tracking, pointers and occupancy; redirect overrides all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_rsp_pending <= 1'b0;
      r_rsp_pc      <= 64'h0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (w_redirect) begin
      r_pc          <= w_load_pc;
      r_rsp_pending <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_rsp_pending <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + 64'd4;
        r_rsp_pc <= r_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // queue storage; contents need no reset because the head is masked by count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wr_ptr] <= fq.imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // sticky halt: set by a misaligned redirect, cleared by an aligned one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_halt <= 1'b0;
    else if (w_redirect) r_halt <= |fq.redirect_pc[1:0];
  end

  assign fq.pc_misaligned = r_halt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed cycle-by-cycle vectors for fetch_queue with
// RESET_PC=0x1000, DEPTH=4, against a one-cycle synchronous memory model.
`timescale 1ns/1ps

module tb_fetch_queue;
  logic clk;
  logic rst_n;

  fetch_queue_if bus();

  fetch_queue #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fq   (bus.master)
  );

  typedef struct {
    logic        rst_b4;
    logic        ready;
    logic        rv;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] ipc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  int cur = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  // instruction memory: data the cycle after a request, garbage otherwise
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? word_of(bus.imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic add(input logic rb, input logic rdy, input logic rv, input logic [63:0] rpc,
                     input logic req, input logic [63:0] addr, input logic valid,
                     input logic [63:0] ipc, input logic mis);
    vec_t t;
    t.rst_b4 = rb; t.ready = rdy; t.rv = rv; t.rpc = rpc;
    t.req = req; t.addr = addr; t.valid = valid; t.ipc = ipc; t.mis = mis;
    vecs.push_back(t);
  endtask

  // called just after a rising edge; asserts reset mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready = 1'b0;
    #1;
    chk("rst_imem_req", {63'h0, bus.imem_req}, 64'h0);
    chk("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("rst_inst", {32'h0, bus.inst}, 64'h0);
    chk("rst_inst_pc", bus.inst_pc, 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("rst_pc_misaligned", {63'h0, bus.pc_misaligned}, 64'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;

    // rb rdy rv rpc            req addr           v  inst_pc        mis
    // reset release, streaming
    add(1, 1, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h1004, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h1008, 1, 64'h1000, 0);
    add(0, 1, 0, 64'h0,    1, 64'h100C, 1, 64'h1004, 0);
    add(0, 1, 0, 64'h0,    1, 64'h1010, 1, 64'h1008, 0);
    // mid-run reset, then decode stalled for 10 cycles: queue fills to 4
    add(1, 0, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    0);
    add(0, 0, 0, 64'h0,    1, 64'h1004, 0, 64'h0,    0);
    add(0, 0, 0, 64'h0,    1, 64'h1008, 1, 64'h1000, 0);
    add(0, 0, 0, 64'h0,    1, 64'h100C, 1, 64'h1000, 0);
    add(0, 0, 0, 64'h0,    0, 64'h1010, 1, 64'h1000, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 64'h0,  0, 64'h1010, 1, 64'h1000, 0);
    // decode resumes: order preserved, fetch restarts the cycle after first pop
    add(0, 1, 0, 64'h0,    0, 64'h1010, 1, 64'h1000, 0);
    add(0, 1, 0, 64'h0,    1, 64'h1010, 1, 64'h1004, 0);
    add(0, 1, 0, 64'h0,    1, 64'h1014, 1, 64'h1008, 0);
    add(0, 1, 0, 64'h0,    1, 64'h1018, 1, 64'h100C, 0);
    add(0, 1, 0, 64'h0,    1, 64'h101C, 1, 64'h1010, 0);
    // 3 queued + 1 in flight, redirect coinciding with a handshake
    add(1, 0, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    0);
    add(0, 0, 0, 64'h0,    1, 64'h1004, 0, 64'h0,    0);
    add(0, 0, 0, 64'h0,    1, 64'h1008, 1, 64'h1000, 0);
    add(0, 0, 0, 64'h0,    1, 64'h100C, 1, 64'h1000, 0);
    add(0, 1, 1, 64'h2000, 0, 64'h1010, 1, 64'h1000, 0);
    add(0, 1, 0, 64'h0,    1, 64'h2000, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h2004, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h2008, 1, 64'h2000, 0);
    add(0, 1, 0, 64'h0,    1, 64'h200C, 1, 64'h2004, 0);
    // redirect with pop, then back-to-back redirects: last wins
    add(0, 1, 1, 64'h3000, 0, 64'h2010, 1, 64'h2008, 0);
    add(0, 1, 1, 64'h4000, 0, 64'h3000, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h4000, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h4004, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h4008, 1, 64'h4000, 0);
    add(0, 1, 0, 64'h0,    1, 64'h400C, 1, 64'h4004, 0);
    // PC wrap
    add(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h4010, 1, 64'h4008, 0);
    add(0, 1, 0, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h0, 0);
    add(0, 1, 0, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0);
    add(0, 1, 0, 64'h0,    1, 64'h0,    1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    add(0, 1, 0, 64'h0,    1, 64'h4,    1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    add(0, 1, 0, 64'h0,    1, 64'h8,    1, 64'h0,    0);
`ifdef FETCH_ALIGN_CHECK_EN
    // misaligned target halts fetch until an aligned redirect
    add(0, 1, 1, 64'h2002, 0, 64'hC,    1, 64'h4,    0);
    add(0, 1, 0, 64'h0,    0, 64'h2002, 0, 64'h0,    1);
    add(0, 1, 0, 64'h0,    0, 64'h2002, 0, 64'h0,    1);
    add(0, 1, 1, 64'h2004, 0, 64'h2002, 0, 64'h0,    1);
    add(0, 1, 0, 64'h0,    1, 64'h2004, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h2008, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h200C, 1, 64'h2004, 0);
`else
    // low target bits are dropped
    add(0, 1, 1, 64'h5003, 0, 64'hC,    1, 64'h4,    0);
    add(0, 1, 0, 64'h0,    1, 64'h5000, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h5004, 0, 64'h0,    0);
    add(0, 1, 0, 64'h0,    1, 64'h5008, 1, 64'h5000, 0);
`endif

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      cur = i;
      if (vecs[i].rst_b4) do_reset();
      bus.inst_ready     = vecs[i].ready;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk("imem_req", {63'h0, bus.imem_req}, {63'h0, vecs[i].req});
      chk("imem_addr", bus.imem_addr, vecs[i].addr);
      chk("inst_valid", {63'h0, bus.inst_valid}, {63'h0, vecs[i].valid});
      if (vecs[i].valid) begin
        chk("inst_pc", bus.inst_pc, vecs[i].ipc);
        chk("inst", {32'h0, bus.inst}, {32'h0, word_of(vecs[i].ipc)});
      end
`ifdef FETCH_ALIGN_CHECK_EN
      chk("pc_misaligned", {63'h0, bus.pc_misaligned}, {63'h0, vecs[i].mis});
`endif
      @(posedge clk);
      #1;
    end

    // redirect latency: first valid instruction three cycles after redirect
    cur = vecs.size();
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h6000;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    n = 1;
    while (!bus.inst_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("redirect_latency", 64'(n), 64'd3);
    chk("redirect_head_pc", bus.inst_pc, 64'h6000);
    chk("redirect_head_inst", {32'h0, bus.inst}, {32'h0, word_of(64'h6000)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
